// File: rtl/dual_counter_compare.sv
// dual_counter_compare: two-channel up/down counter pair with run-control FSM,
// registered magnitude compare, A==B match-event counter and match-limit stop.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_start/i_stop/i_clear  run control (clear -> counters, flags, FSM to 0/IDLE)
//   i_a_load/_val/_down     channel A load and direction
//   i_b_load/_val/_down     channel B load (also restarts prescaler) and direction
//   i_match_limit           match count that ends the run (0 = unlimited)
//   o_a_q/o_b_q             counter values
//   o_a_gt_b/eq/lt          registered compare of the counters
//   o_match_pulse/_cnt      new-equality pulse and saturating event count
//   o_state/o_done          0 IDLE, 1 RUN, 2 DONE; done mirrors DONE
module dual_counter_compare #(
   parameter int WIDTH    = 4,
   parameter int MATCH_W  = 8,
   parameter int B_DIV    = 1,
   parameter int SATURATE = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic               i_clear,
   input  logic               i_a_load,
   input  logic [WIDTH-1:0]   i_a_load_val,
   input  logic               i_a_down,
   input  logic               i_b_load,
   input  logic [WIDTH-1:0]   i_b_load_val,
   input  logic               i_b_down,
   input  logic [MATCH_W-1:0] i_match_limit,
   output logic [WIDTH-1:0]   o_a_q,
   output logic [WIDTH-1:0]   o_b_q,
   output logic               o_a_gt_b,
   output logic               o_a_eq_b,
   output logic               o_a_lt_b,
   output logic               o_match_pulse,
   output logic [MATCH_W-1:0] o_match_cnt,
   output logic [1:0]         o_state,
   output logic               o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int PW = (B_DIV > 1) ? $clog2(B_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(B_DIV - 1);
   localparam logic [MATCH_W-1:0] C_MAX = '1;

   state_t             r_state;
   logic               r_done;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [PW-1:0]      r_presc;
   logic               r_gt;
   logic               r_eq;
   logic               r_lt;
   logic               r_pulse;
   logic [MATCH_W-1:0] r_cnt;

   logic               w_run;
   logic               w_evt;
   logic [MATCH_W-1:0] w_cnt_nxt;
   logic               w_hit;
   logic               w_cnt_en;
   logic               w_b_tick;
   logic [WIDTH-1:0]   w_a_step;
   logic [WIDTH-1:0]   w_b_step;

   function automatic logic [WIDTH-1:0] f_step(
      input logic [WIDTH-1:0] v,
      input logic             dn
   );
      logic [WIDTH-1:0] r;
      if (dn) begin
         if (SATURATE != 0 && v == '0) r = v;
         else                          r = v - 1'b1;
      end else begin
         if (SATURATE != 0 && v == '1) r = v;
         else                          r = v + 1'b1;
      end
      return r;
   endfunction

   assign w_run     = (r_state == S_RUN);
   // New equality only: the lagging eq flag suppresses repeats.
   assign w_evt     = w_run && (r_a == r_b) && !r_eq;
   assign w_cnt_nxt = (w_evt && r_cnt != C_MAX) ? r_cnt + 1'b1 : r_cnt;
   assign w_hit     = w_evt && (i_match_limit != '0)
                      && (w_cnt_nxt == i_match_limit);
   // The limit-reaching edge does not step, so the counters freeze on
   // the matching values.
   assign w_cnt_en  = w_run && !w_hit;
   assign w_b_tick  = w_cnt_en && (r_presc == P_LAST);
   assign w_a_step  = f_step(r_a, i_a_down);
   assign w_b_step  = f_step(r_b, i_b_down);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_presc <= '0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_presc <= '0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_gt    <= (r_a > r_b);
         r_eq    <= (r_a == r_b);
         r_lt    <= (r_a < r_b);
         r_pulse <= w_evt;
         r_cnt   <= w_cnt_nxt;

         if (i_a_load)      r_a <= i_a_load_val;
         else if (w_cnt_en) r_a <= w_a_step;

         if (i_b_load)      r_b <= i_b_load_val;
         else if (w_b_tick) r_b <= w_b_step;

         if (i_b_load)
            r_presc <= '0;
         else if (w_cnt_en)
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;

         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) r_state <= S_RUN;
            end
            S_RUN: begin
               if (i_stop) begin
                  r_state <= S_IDLE;
               end else if (w_hit) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_a_q         = r_a;
   assign o_b_q         = r_b;
   assign o_a_gt_b      = r_gt;
   assign o_a_eq_b      = r_eq;
   assign o_a_lt_b      = r_lt;
   assign o_match_pulse = r_pulse;
   assign o_match_cnt   = r_cnt;
   assign o_state       = r_state;
   assign o_done        = r_done;

endmodule

// File: tb/tb_dual_counter_compare.sv
// Bench for dual_counter_compare: three instances (default, B_DIV=3,
// SATURATE=1) share stimulus; directed, table and random checks.
module tb_dual_counter_compare;
   localparam int W  = 4;
   localparam int MW = 8;

   logic clk = 1'b0;
   logic rst;
   logic start, stop, clear;
   logic a_load, b_load, a_down, b_down;
   logic [W-1:0]  a_val, b_val;
   logic [MW-1:0] lim;

   logic [W-1:0]  a_q [3];
   logic [W-1:0]  b_q [3];
   logic          gt  [3];
   logic          eq  [3];
   logic          lt  [3];
   logic          pul [3];
   logic [MW-1:0] mc  [3];
   logic [1:0]    st  [3];
   logic          dn  [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dual_counter_compare #(.WIDTH(W), .MATCH_W(MW), .B_DIV(1), .SATURATE(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_clear(clear), .i_a_load(a_load), .i_a_load_val(a_val),
      .i_a_down(a_down), .i_b_load(b_load), .i_b_load_val(b_val),
      .i_b_down(b_down), .i_match_limit(lim),
      .o_a_q(a_q[0]), .o_b_q(b_q[0]), .o_a_gt_b(gt[0]), .o_a_eq_b(eq[0]),
      .o_a_lt_b(lt[0]), .o_match_pulse(pul[0]), .o_match_cnt(mc[0]),
      .o_state(st[0]), .o_done(dn[0]));

   dual_counter_compare #(.WIDTH(W), .MATCH_W(MW), .B_DIV(3), .SATURATE(0)) u_div (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_clear(clear), .i_a_load(a_load), .i_a_load_val(a_val),
      .i_a_down(a_down), .i_b_load(b_load), .i_b_load_val(b_val),
      .i_b_down(b_down), .i_match_limit(lim),
      .o_a_q(a_q[1]), .o_b_q(b_q[1]), .o_a_gt_b(gt[1]), .o_a_eq_b(eq[1]),
      .o_a_lt_b(lt[1]), .o_match_pulse(pul[1]), .o_match_cnt(mc[1]),
      .o_state(st[1]), .o_done(dn[1]));

   dual_counter_compare #(.WIDTH(W), .MATCH_W(MW), .B_DIV(1), .SATURATE(1)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_clear(clear), .i_a_load(a_load), .i_a_load_val(a_val),
      .i_a_down(a_down), .i_b_load(b_load), .i_b_load_val(b_val),
      .i_b_down(b_down), .i_match_limit(lim),
      .o_a_q(a_q[2]), .o_b_q(b_q[2]), .o_a_gt_b(gt[2]), .o_a_eq_b(eq[2]),
      .o_a_lt_b(lt[2]), .o_match_pulse(pul[2]), .o_match_cnt(mc[2]),
      .o_state(st[2]), .o_done(dn[2]));

   // Reference model, integer arithmetic, one entry per instance.
   int m_a [3], m_b [3], m_p [3], m_st [3], m_cnt [3];
   bit m_gt [3], m_eq [3], m_lt [3], m_pul [3];

   function automatic int div_of(int i);
      return (i == 1) ? 3 : 1;
   endfunction

   function automatic bit sat_of(int i);
      return (i == 2);
   endfunction

   function automatic int stepv(int v, bit down, bit sat);
      int r;
      r = down ? v - 1 : v + 1;
      if (sat) begin
         if (r < 0)  r = 0;
         if (r > 15) r = 15;
      end else begin
         r = (r + 16) % 16;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_a[i] = 0; m_b[i] = 0; m_p[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
         m_gt[i] = 0; m_eq[i] = 0; m_lt[i] = 0; m_pul[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         bit evt, hit, on;
         int nc, na, nb, np, ns;
         if (clear) begin
            m_a[i] = 0; m_b[i] = 0; m_p[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
            m_gt[i] = 0; m_eq[i] = 0; m_lt[i] = 0; m_pul[i] = 0;
         end else begin
            evt = (m_st[i] == 1) && (m_a[i] == m_b[i]) && !m_eq[i];
            nc  = m_cnt[i] + ((evt && m_cnt[i] < 255) ? 1 : 0);
            hit = evt && (lim != 0) && (nc == int'(lim));
            on  = (m_st[i] == 1) && !hit;
            na  = a_load ? int'(a_val)
                : on ? stepv(m_a[i], a_down, sat_of(i)) : m_a[i];
            nb  = b_load ? int'(b_val)
                : (on && m_p[i] == div_of(i) - 1)
                  ? stepv(m_b[i], b_down, sat_of(i)) : m_b[i];
            np  = b_load ? 0 : on ? (m_p[i] + 1) % div_of(i) : m_p[i];
            if (m_st[i] == 0)      ns = start ? 1 : 0;
            else if (m_st[i] == 1) ns = stop ? 0 : (hit ? 2 : 1);
            else                   ns = 2;
            m_gt[i] = m_a[i] > m_b[i];
            m_eq[i] = m_a[i] == m_b[i];
            m_lt[i] = m_a[i] < m_b[i];
            m_pul[i] = evt;
            m_cnt[i] = nc;
            m_a[i] = na; m_b[i] = nb; m_p[i] = np; m_st[i] = ns;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         bit ok;
         ok = (int'(a_q[i]) == m_a[i]) && (int'(b_q[i]) == m_b[i])
           && (int'(st[i]) == m_st[i]) && (gt[i] == m_gt[i])
           && (eq[i] == m_eq[i]) && (lt[i] == m_lt[i])
           && (pul[i] == m_pul[i]) && (int'(mc[i]) == m_cnt[i])
           && (dn[i] == (m_st[i] == 2));
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL model inst%0d t=%0t: got a=%0d b=%0d st=%0d gel=%0d%0d%0d p=%0d c=%0d d=%0d; want a=%0d b=%0d st=%0d gel=%0d%0d%0d p=%0d c=%0d",
               i, $time, a_q[i], b_q[i], st[i], gt[i], eq[i], lt[i], pul[i], mc[i], dn[i],
               m_a[i], m_b[i], m_st[i], m_gt[i], m_eq[i], m_lt[i], m_pul[i], m_cnt[i]);
         end
      end
   endtask

   task automatic check_val(string name, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; clear = 0; a_load = 0; b_load = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   typedef struct {
      logic st_, sp, cl, al;
      logic [3:0] av;
      logic bl;
      logic [3:0] bv;
      logic ad, bd;
      int ea, eb, es;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pulses, k;
      bit got;
      vecs[0]  = '{0,0,1,0, 0,0, 0,0,0,  0, 0,0};
      vecs[1]  = '{0,0,0,1, 3,1, 9,0,0,  3, 9,0};
      vecs[2]  = '{1,0,0,0, 0,0, 0,1,0,  3, 9,1};
      vecs[3]  = '{0,0,0,0, 0,0, 0,1,0,  2,10,1};
      vecs[4]  = '{0,0,0,1,15,0, 0,1,0, 15,11,1};
      vecs[5]  = '{1,1,0,0, 0,0, 0,1,0, 14,12,0};
      vecs[6]  = '{0,0,0,0, 0,0, 0,1,0, 14,12,0};
      vecs[7]  = '{0,0,1,1, 6,0, 0,0,0,  0, 0,0};
      vecs[8]  = '{1,0,0,0, 0,0, 0,1,1,  0, 0,1};
      vecs[9]  = '{0,0,0,0, 0,0, 0,1,1, 15,15,1};
      vecs[10] = '{0,1,0,0, 0,0, 0,1,1, 14,14,0};

      idle_inputs();
      a_val = 0; b_val = 0; a_down = 0; b_down = 0; lim = 0;
      rst = 1;
      model_reset();
      @(negedge clk);
      check_val("reset_state", int'(st[0]), 0);
      check_val("reset_flags", {gt[0], eq[0], lt[0]}, 0);
      check_all();
      rst = 0;
      tick();
      check_val("post_reset_eq", eq[0], 1);

      // Async reset mid-run with a=7
      a_load = 1; a_val = 7; start = 1;
      tick();
      idle_inputs();
      check_val("t1_a_before_rst", int'(a_q[0]), 7);
      check_val("t1_run_before_rst", int'(st[0]), 1);
      #2 rst = 1;
      #1;
      check_val("t1_rst_a", int'(a_q[0]), 0);
      check_val("t1_rst_state", int'(st[0]), 0);
      check_val("t1_rst_flags", {gt[0], eq[0], lt[0], pul[0], dn[0]}, 0);
      model_reset();
      @(negedge clk);
      rst = 0;

      // Wrap / match / limit
      a_load = 1; a_val = 0; b_load = 1; b_val = 10;
      a_down = 0; b_down = 1; lim = 2;
      tick();
      idle_inputs();
      start = 1;
      tick();
      start = 0;
      pulses = 0; got = 0;
      for (k = 0; k < 30 && !got; k++) begin
         tick();
         if (pul[0]) pulses++;
         if (st[0] == 2'd2) got = 1;
      end
      check_val("t2_reached_done", got, 1);
      check_val("t2_run_cycles", k, 14);
      check_val("t2_pulses", pulses, 2);
      check_val("t2_match_cnt", int'(mc[0]), 2);
      check_val("t2_done", dn[0], 1);
      check_val("t2_done_pulse", pul[0], 1);
      tick(); tick();
      check_val("t2_freeze_a", int'(a_q[0]), 13);
      check_val("t2_freeze_b", int'(b_q[0]), 13);
      check_val("t2_eq", eq[0], 1);
      start = 1;
      tick();
      start = 0;
      check_val("t5_start_in_done", int'(st[0]), 2);
      clear = 1;
      tick();
      clear = 0;
      check_val("t5_clear_done", int'(st[0]), 0);

      // Prescale B_DIV=3
      lim = 0; a_down = 0; b_down = 0;
      a_load = 1; a_val = 0; b_load = 1; b_val = 0;
      tick();
      idle_inputs();
      start = 1;
      tick();
      start = 0;
      for (int j = 1; j <= 9; j++) begin
         tick();
         check_val($sformatf("t3_b_cyc%0d", j), int'(b_q[1]), j / 3);
      end
      check_val("t3_a", int'(a_q[1]), 9);
      stop = 1;
      tick();
      stop = 0;

      // Saturation
      a_load = 1; a_val = 14; b_load = 1; b_val = 1;
      a_down = 0; b_down = 1;
      tick();
      idle_inputs();
      start = 1;
      tick();
      start = 0;
      pulses = 0;
      for (int j = 0; j < 4; j++) begin
         tick();
         if (pul[2]) pulses++;
      end
      check_val("t4_a_sat", int'(a_q[2]), 15);
      check_val("t4_b_sat", int'(b_q[2]), 0);
      check_val("t4_gt", gt[2], 1);
      check_val("t4_no_pulse", pulses, 0);
      stop = 1;
      tick();
      stop = 0;

      // start+stop in RUN
      start = 1;
      tick();
      check_val("t5_in_run", int'(st[0]), 1);
      stop = 1;
      tick();
      idle_inputs();
      check_val("t5_stop_wins", int'(st[0]), 0);
      a_load = 1; a_val = 6; clear = 1;
      tick();
      idle_inputs();
      check_val("t5_clear_over_load", int'(a_q[0]), 0);

      // Sustained equality
      a_load = 1; a_val = 1; b_load = 1; b_val = 2;
      tick();
      a_val = 4; b_val = 4; a_down = 0; b_down = 0; start = 1;
      tick();
      idle_inputs();
      pulses = 0;
      for (int j = 0; j < 5; j++) begin
         tick();
         if (pul[0]) pulses++;
      end
      check_val("t6_pulses", pulses, 1);
      check_val("t6_cnt", int'(mc[0]), 1);
      check_val("t6_eq", eq[0], 1);

      // Table vectors (instance 0)
      for (int v = 0; v < 11; v++) begin
         start = vecs[v].st_; stop = vecs[v].sp; clear = vecs[v].cl;
         a_load = vecs[v].al; a_val = vecs[v].av;
         b_load = vecs[v].bl; b_val = vecs[v].bv;
         a_down = vecs[v].ad; b_down = vecs[v].bd;
         tick();
         check_val($sformatf("vec%0d_a", v), int'(a_q[0]), vecs[v].ea);
         check_val($sformatf("vec%0d_b", v), int'(b_q[0]), vecs[v].eb);
         check_val($sformatf("vec%0d_st", v), int'(st[0]), vecs[v].es);
      end
      idle_inputs();

      // Random stimulus against the model
      for (int r = 0; r < 600; r++) begin
         if (r % 50 == 0) lim = MW'($urandom_range(0, 4));
         start  = ($urandom_range(0, 3) == 0);
         stop   = ($urandom_range(0, 15) == 0);
         clear  = ($urandom_range(0, 39) == 0);
         a_load = ($urandom_range(0, 7) == 0);
         b_load = ($urandom_range(0, 7) == 0);
         a_val  = W'($urandom);
         b_val  = W'($urandom);
         a_down = W'($urandom) > 4'd7;
         b_down = W'($urandom) > 4'd7;
         tick();
      end
      idle_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dual_counter_compare.md
Name: dual_counter_compare

Overview:
- Parametrised two-channel counter/comparator: counters A and B advance under a run-control FSM.
- Each channel has its own load, up/down direction and wrap/saturate policy. Counter B has a programmable prescale (B_DIV).
- Registered magnitude-compare flags and an A==B match-event counter are provided. The run stops automatically at a programmable match limit.
- Sits in the processes/stimulus area as a reusable self-checking sequencer for region/ordering experiments and event-count checks.

Parameters:
- WIDTH, 4: bit width of counters A and B.
- MATCH_W, 8: width of the match-event counter and match_limit.
- B_DIV, 1: counter B advances once every B_DIV RUN cycles (1 = every cycle; legal range 1..256).
- SATURATE, 0: 0 = counters wrap modulo 2^WIDTH; 1 = counters hold at all-ones (up) or zero (down).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  IDLE->RUN request.
- stop  in  1  RUN->IDLE request.
- clear  in  1  synchronous clear of counters, match_cnt, flags; FSM to IDLE.
- a_load  in  1  load a_load_val into A.
- a_load_val  in  WIDTH  A load value.
- a_down  in  1  A direction, 0 = up, 1 = down.
- b_load  in  1  load b_load_val into B; also resets B prescaler.
- b_load_val  in  WIDTH  B load value.
- b_down  in  1  B direction.
- match_limit  in  MATCH_W  match count that ends the run; 0 = no limit.
- a_q  out  WIDTH  counter A.
- b_q  out  WIDTH  counter B.
- a_gt_b / a_eq_b / a_lt_b  out  1 each  registered compare of a_q vs b_q.
- match_pulse  out  1  one-cycle pulse per new A==B event in RUN.
- match_cnt  out  MATCH_W  number of match events, saturating at all-ones.
- state  out  2  0 = IDLE, 1 = RUN, 2 = DONE.
- done  out  1  high while state == DONE.

Behaviour:
- Reset (rst high, asynchronous) forces:
  - all outputs to 0, state IDLE, B prescaler to 0;
  - this includes a_gt_b, a_eq_b and a_lt_b.
- FSM transitions:
  - IDLE -> RUN when start.
  - RUN -> IDLE when stop. stop wins over start in the same cycle.
  - RUN -> DONE on the cycle match_cnt becomes equal to a nonzero match_limit.
  - DONE -> IDLE only on clear. start is ignored in DONE.
  - clear from any state -> IDLE.
- Per-counter priority: clear (to 0) > load > count. Loads are honoured in every state. Counting happens only in RUN.
- Counter A steps by ±1 every RUN cycle.
- Counter B prescaler:
  - It counts RUN cycles 0..B_DIV-1.
  - B steps on the cycle the prescaler equals B_DIV-1, then the prescaler returns to 0.
  - The prescaler holds outside RUN.
- Limits: with SATURATE=0, up from all-ones gives 0 and down from 0 gives all-ones. With SATURATE=1 the counter holds at the limit.
- Compare flags:
  - Registered from current a_q/b_q, so they lag the counters by one cycle.
  - They update in every state. Exactly one flag is high after the first post-reset clock.
- match_pulse:
  - Registered. Asserted in cycle t+1 when, in cycle t, state == RUN, a_q == b_q and a_eq_b == 0.
  - A sustained equality therefore produces a single pulse.
- match_cnt increments with each match_pulse and saturates at 2^MATCH_W-1.
- DONE is entered on the same edge that match_cnt reaches match_limit. match_pulse is still high in that cycle.
- Counters freeze in DONE.
- Reset mid-run: immediate asynchronous return to reset values. No pending pulse survives.

Test Plan:
1. Reset: pulse rst mid-RUN with a_q=7 -> all outputs 0 and state=0 within the same cycle, before the next clk edge.
2. Wrap/match/limit (WIDTH=4, B_DIV=1, SATURATE=0): load a=0, b=10, a_down=0, b_down=1, match_limit=2, start.
   - Equality occurs at RUN cycles 5 (5,5) and 13 (13,13).
   - Required: match_pulse twice; match_cnt=2; state=DONE.
   - Counters then freeze at a=13, b=13; a_eq_b=1.
3. Prescale (B_DIV=3): load a=0, b=0, both up, match_limit=0, run 9 cycles.
   - Required: a_q=9, b_q=3.
   - b_q steps exactly on the 3rd, 6th and 9th RUN cycles.
4. Saturate (SATURATE=1): a=14 up, b=1 down, run 4 cycles.
   - Required: a_q holds 15, b_q holds 0; a_gt_b=1.
   - No match_pulse, since a starts above b and never meets it.
5. Priority: assert start and stop together in RUN -> IDLE.
   - Assert a_load (val 6) and clear together -> a_q=0.
   - start in DONE -> remains DONE until clear.
6. Sustained equality: a=b=4, both up, B_DIV=1, run 5 cycles.
   - Required: exactly one match_pulse; match_cnt=1; a_eq_b stays 1.
